// File: rtl/cordic_atan_arb.sv
// Iterative CORDIC vectoring engine returning atan(y/x) in Q8.24 degrees,
// shared by two requesters through a round-robin arbiter.
module cordic_atan_arb #(
  parameter int N_ITER = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic signed [31:0] inx0,
  input  logic signed [31:0] iny0,
  input  logic signed [31:0] inx1,
  input  logic signed [31:0] iny1,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic               out_valid,
  output logic               out_id,
  output logic signed [31:0] out_angle,
  output logic               out_err
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [4:0] LAST = 5'(N_ITER - 1);

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic [1:0]         gnt_q, gnt_d;
  logic signed [33:0] x_q, x_d, y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic [4:0]         i_q, i_d;
  logic               id_q, id_d;
  logic               out_id_q, out_id_d;
  logic signed [31:0] out_angle_q, out_angle_d;
  logic               out_err_q, out_err_d;

  logic               win;
  logic signed [31:0] sel_x, sel_y;
  logic signed [33:0] x_shr, y_shr;
  logic signed [31:0] atan_i;

  // round(atan(2^-i) * 180/pi * 2^24)
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'sd754974720;
      5'd1:    atan_lut = 32'sd445687602;
      5'd2:    atan_lut = 32'sd235489088;
      5'd3:    atan_lut = 32'sd119537938;
      5'd4:    atan_lut = 32'sd60000934;
      5'd5:    atan_lut = 32'sd30029717;
      5'd6:    atan_lut = 32'sd15018522;
      5'd7:    atan_lut = 32'sd7509720;
      5'd8:    atan_lut = 32'sd3754917;
      5'd9:    atan_lut = 32'sd1877466;
      5'd10:   atan_lut = 32'sd938734;
      5'd11:   atan_lut = 32'sd469367;
      5'd12:   atan_lut = 32'sd234684;
      5'd13:   atan_lut = 32'sd117342;
      5'd14:   atan_lut = 32'sd58671;
      5'd15:   atan_lut = 32'sd29335;
      5'd16:   atan_lut = 32'sd14668;
      5'd17:   atan_lut = 32'sd7334;
      5'd18:   atan_lut = 32'sd3667;
      5'd19:   atan_lut = 32'sd1833;
      5'd20:   atan_lut = 32'sd917;
      5'd21:   atan_lut = 32'sd458;
      5'd22:   atan_lut = 32'sd229;
      5'd23:   atan_lut = 32'sd115;
      5'd24:   atan_lut = 32'sd57;
      5'd25:   atan_lut = 32'sd29;
      5'd26:   atan_lut = 32'sd14;
      5'd27:   atan_lut = 32'sd7;
      5'd28:   atan_lut = 32'sd4;
      5'd29:   atan_lut = 32'sd2;
      5'd30:   atan_lut = 32'sd1;
      default: atan_lut = 32'sd0;
    endcase
  endfunction

  // prio_q names the requester that wins when both ask at once
  assign win    = (req == 2'b11) ? prio_q : req[1];
  assign sel_x  = win ? inx1 : inx0;
  assign sel_y  = win ? iny1 : iny0;
  assign x_shr  = x_q >>> i_q;
  assign y_shr  = y_q >>> i_q;
  assign atan_i = atan_lut(i_q);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_d       = 2'b00;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    id_d        = id_q;
    out_id_d    = out_id_q;
    out_angle_d = out_angle_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d  = win ? 2'b10 : 2'b01;
          prio_d = ~win;
          id_d   = win;
          if (sel_x[31]) begin
            state_d     = DONE;
            out_err_d   = 1'b1;
            out_angle_d = '0;
            out_id_d    = win;
          end else begin
            x_d     = {{2{sel_x[31]}}, sel_x};
            y_d     = {{2{sel_y[31]}}, sel_y};
            z_d     = '0;
            i_d     = '0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        // rotate toward y = 0; direction follows the current residual y
        if (!y_q[33]) begin
          x_d = x_q + y_shr;
          y_d = y_q - x_shr;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_shr;
          y_d = y_q + x_shr;
          z_d = z_q - atan_i;
        end
        i_d = i_q + 5'd1;
        if (i_q == LAST) begin
          state_d     = DONE;
          out_angle_d = z_d;
          out_err_d   = 1'b0;
          out_id_d    = id_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      gnt_q       <= 2'b00;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      id_q        <= 1'b0;
      out_id_q    <= 1'b0;
      out_angle_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      id_q        <= id_d;
      out_id_q    <= out_id_d;
      out_angle_q <= out_angle_d;
      out_err_q   <= out_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_id    = out_id_q;
  assign out_angle = out_angle_q;
  assign out_err   = out_err_q;

endmodule
